// File: rtl/alu_operand_seq.sv
// Operand sequencer: 4x16 register file and carry flag driving an external combinational ALU.
// Define ALU_OPERAND_SEQ_ZERO_FLAG_EN to add a zero-result flag output.
module alu_operand_seq #(
    parameter logic INIT_CARRY = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [1:0]  cmd_rd,
    input  logic [1:0]  cmd_rs1,
    input  logic [1:0]  cmd_rs2,
    input  logic        cmd_use_c,
    input  logic        ld_valid,
    input  logic [1:0]  ld_addr,
    input  logic [15:0] ld_data,
    input  logic [1:0]  rd_addr,
    output logic [15:0] rd_data,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_cin,
    output logic [2:0]  alu_ctrl,
    input  logic [15:0] alu_result,
    input  logic        alu_cout,
    output logic        done,
    output logic        carry
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
    ,
    output logic        zero
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] rf_q [4];
    logic [15:0] rf_d [4];
    logic        carry_q, carry_d;
    logic [15:0] alu_a_q, alu_a_d;
    logic [15:0] alu_b_q, alu_b_d;
    logic        alu_cin_q, alu_cin_d;
    logic [2:0]  alu_ctrl_q, alu_ctrl_d;
    logic [1:0]  rd_q, rd_d;
    logic [2:0]  op_q, op_d;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
    logic        zero_q, zero_d;
`endif

    always_comb begin
        state_d    = state_q;
        rf_d       = rf_q;
        carry_d    = carry_q;
        alu_a_d    = alu_a_q;
        alu_b_d    = alu_b_q;
        alu_cin_d  = alu_cin_q;
        alu_ctrl_d = alu_ctrl_q;
        rd_d       = rd_q;
        op_d       = op_q;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
        zero_d     = zero_q;
`endif

        if (ld_valid) begin
            rf_d[ld_addr] = ld_data;
        end

        unique case (state_q)
            ST_IDLE: begin
                // Operands come from rf_q, so a coincident load is not seen.
                if (cmd_valid) begin
                    alu_a_d    = rf_q[cmd_rs1];
                    alu_b_d    = rf_q[cmd_rs2];
                    alu_ctrl_d = cmd_op;
                    alu_cin_d  = cmd_use_c & carry_q;
                    rd_d       = cmd_rd;
                    op_d       = cmd_op;
                    state_d    = ST_EXEC;
                end
            end
            ST_EXEC: begin
                // Assigned after the load so the writeback wins on a collision.
                rf_d[rd_q] = alu_result;
                if (op_q == 3'b000 || op_q == 3'b001) begin
                    carry_d = alu_cout;
                end
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
                zero_d     = (alu_result == 16'h0000);
`endif
                alu_a_d    = '0;
                alu_b_d    = '0;
                alu_cin_d  = 1'b0;
                alu_ctrl_d = '0;
                state_d    = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rf_q       <= '{default: '0};
            carry_q    <= INIT_CARRY;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_cin_q  <= 1'b0;
            alu_ctrl_q <= '0;
            rd_q       <= '0;
            op_q       <= '0;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
            zero_q     <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            rf_q       <= rf_d;
            carry_q    <= carry_d;
            alu_a_q    <= alu_a_d;
            alu_b_q    <= alu_b_d;
            alu_cin_q  <= alu_cin_d;
            alu_ctrl_q <= alu_ctrl_d;
            rd_q       <= rd_d;
            op_q       <= op_d;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
            zero_q     <= zero_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign rd_data   = rf_q[rd_addr];
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_cin   = alu_cin_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign carry     = carry_q;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
    assign zero      = zero_q;
`endif

endmodule

// File: tb/tb_alu_operand_seq.sv
// Directed bench for alu_operand_seq: behavioural ALU, register-file model and result scoreboard.
module tb_alu_operand_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [1:0]  cmd_rd, cmd_rs1, cmd_rs2;
    logic        cmd_use_c;
    logic        ld_valid;
    logic [1:0]  ld_addr;
    logic [15:0] ld_data;
    logic [1:0]  rd_addr;
    logic [15:0] rd_data;
    logic [15:0] alu_a, alu_b;
    logic        alu_cin;
    logic [2:0]  alu_ctrl;
    logic [15:0] alu_result;
    logic        alu_cout;
    logic        done;
    logic        carry;
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
    logic        zero;
`endif

    always #5 clk = ~clk;

    alu_operand_seq #(.INIT_CARRY(1'b0)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_use_c(cmd_use_c),
        .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_cin(alu_cin), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_cout(alu_cout),
        .done(done), .carry(carry)
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
        , .zero(zero)
`endif
    );

    // Returns {cout, result}; sub reports borrow, shifts report the bit shifted out.
    function automatic logic [16:0] alu_ref(input logic [2:0] op, input logic [15:0] a,
                                            input logic [15:0] b, input logic cin);
        case (op)
            3'd0:    return {1'b0, a} + {1'b0, b} + {16'd0, cin};
            3'd1:    return {1'b0, a} - {1'b0, b} - {16'd0, cin};
            3'd2:    return {1'b0, a | b};
            3'd3:    return {1'b0, a & b};
            3'd4:    return {a[15], a[14:0], 1'b0};
            3'd5:    return {a[0], 1'b0, a[15:1]};
            3'd6:    return {a[15], a[14:0], a[15]};
            default: return {a[0], a[0], a[15:1]};
        endcase
    endfunction

    always_comb {alu_cout, alu_result} = alu_ref(alu_ctrl, alu_a, alu_b, alu_cin);

    typedef struct packed {
        logic [1:0]  rd;
        logic [15:0] res;
        logic        c;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] m_rf [4];
    logic        m_carry;
    int          n_total = 0;
    int          n_pass  = 0;
    int          n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            rd_addr = 2'(i);
            #1;
            check(tag, rd_data, m_rf[i]);
        end
    endtask

    task automatic push_cmd(input logic [2:0] op, input logic [1:0] rd,
                            input logic [1:0] rs1, input logic [1:0] rs2, input logic usec);
        logic [16:0] r;
        exp_t        e;
        r     = alu_ref(op, m_rf[rs1], m_rf[rs2], usec & m_carry);
        e.rd  = rd;
        e.res = r[15:0];
        e.c   = (op == 3'd0 || op == 3'd1) ? r[16] : m_carry;
        sb.push_back(e);
    endtask

    task automatic check_writeback(input string tag);
        exp_t e;
        check({tag, "_pending"}, 32'(sb.size() > 0), 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        m_rf[e.rd] = e.res;
        m_carry    = e.c;
        rd_addr    = e.rd;
        #1;
        check({tag, "_rd"}, rd_data, e.res);
        check({tag, "_carry"}, carry, e.c);
        check_regs({tag, "_rf"});
    endtask

    task automatic do_ld(input logic [1:0] a, input logic [15:0] d);
        ld_valid = 1'b1;
        ld_addr  = a;
        ld_data  = d;
        tick();
        ld_valid = 1'b0;
        m_rf[a]  = d;
    endtask

    // ld_phase: 0 none, 1 load coincides with accept, 2 load during EXEC
    task automatic run_cmd(input string tag, input logic [2:0] op, input logic [1:0] rd,
                           input logic [1:0] rs1, input logic [1:0] rs2, input logic usec,
                           input int ld_phase, input logic [1:0] la, input logic [15:0] ld);
        logic [15:0] ea, eb;
        logic        ecin;
        check({tag, "_ready_idle"}, cmd_ready, 1);
        ea   = m_rf[rs1];
        eb   = m_rf[rs2];
        ecin = usec & m_carry;
        push_cmd(op, rd, rs1, rs2, usec);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_rd    = rd;
        cmd_rs1   = rs1;
        cmd_rs2   = rs2;
        cmd_use_c = usec;
        if (ld_phase == 1) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ld;
        end
        tick();
        cmd_valid = 1'b0;
        ld_valid  = 1'b0;
        if (ld_phase == 1) m_rf[la] = ld;
        check({tag, "_exec_a"}, alu_a, ea);
        check({tag, "_exec_b"}, alu_b, eb);
        check({tag, "_exec_cin"}, alu_cin, ecin);
        check({tag, "_exec_ctrl"}, alu_ctrl, op);
        check({tag, "_exec_ready"}, cmd_ready, 0);
        check({tag, "_exec_done"}, done, 0);
        if (ld_phase == 2) begin
            ld_valid = 1'b1; ld_addr = la; ld_data = ld;
            #1;
            check({tag, "_exec_a_hold"}, alu_a, ea);
        end
        tick();
        ld_valid = 1'b0;
        if (ld_phase == 2) m_rf[la] = ld;
        check({tag, "_done"}, done, 1);
        check({tag, "_done_ready"}, cmd_ready, 0);
        check({tag, "_done_a_clr"}, alu_a, 0);
        check({tag, "_done_ctrl_clr"}, {alu_b, alu_cin, alu_ctrl}, 0);
`ifdef ALU_OPERAND_SEQ_ZERO_FLAG_EN
        if (sb.size() > 0) check({tag, "_zero"}, zero, 32'(sb[0].res == 16'h0000));
`endif
        check_writeback(tag);
        tick();
        check({tag, "_done_pulse_end"}, done, 0);
    endtask

    logic [2:0] b_op  [4] = '{3'd0, 3'd1, 3'd6, 3'd3};
    logic [1:0] b_rd  [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
    logic [1:0] b_rs1 [4] = '{2'd1, 2'd0, 2'd1, 2'd2};
    logic [1:0] b_rs2 [4] = '{2'd2, 2'd3, 2'd0, 2'd0};

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, dn, last_acc;
        rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs1 = '0; cmd_rs2 = '0;
        cmd_use_c = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
        m_rf = '{default: '0};
        m_carry = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        check("rst_ready", cmd_ready, 1);
        check("rst_done", done, 0);
        check("rst_carry", carry, 0);
        check("rst_alu", {alu_a, alu_b, alu_cin, alu_ctrl}, 0);
        check_regs("rst_rf");

        // FFFF + 0001 -> 0000 with carry out
        do_ld(2'd0, 16'hFFFF);
        do_ld(2'd1, 16'h0001);
        run_cmd("add_wrap", 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 0, 2'd0, 16'h0);

        // carry-in consumed: 5 + 3 + 1 = 9, carry cleared
        do_ld(2'd0, 16'h0005);
        do_ld(2'd1, 16'h0003);
        run_cmd("add_cin", 3'd0, 2'd3, 2'd0, 2'd1, 1'b1, 0, 2'd0, 16'h0);

        // set carry, then non-arithmetic ops must leave it alone
        do_ld(2'd0, 16'hFFFF);
        run_cmd("add_setc", 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 0, 2'd0, 16'h0);
        do_ld(2'd0, 16'h8001);
        run_cmd("rol", 3'd6, 2'd0, 2'd0, 2'd0, 1'b0, 0, 2'd0, 16'h0);
        run_cmd("ror", 3'd7, 2'd1, 2'd2, 2'd0, 1'b0, 0, 2'd0, 16'h0);
        run_cmd("or", 3'd2, 2'd3, 2'd0, 2'd2, 1'b1, 0, 2'd0, 16'h0);
        run_cmd("sub_borrow", 3'd1, 2'd3, 2'd1, 2'd0, 1'b1, 0, 2'd0, 16'h0);
        run_cmd("sub", 3'd1, 2'd2, 2'd0, 2'd1, 1'b0, 0, 2'd0, 16'h0);
        run_cmd("shl", 3'd4, 2'd1, 2'd3, 2'd0, 1'b0, 0, 2'd0, 16'h0);
        run_cmd("shr", 3'd5, 2'd0, 2'd3, 2'd0, 1'b0, 0, 2'd0, 16'h0);
        run_cmd("and", 3'd3, 2'd2, 2'd0, 2'd3, 1'b0, 0, 2'd0, 16'h0);

        // load collisions and operand snapshots
        run_cmd("wb_wins", 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 2, 2'd2, 16'hBEEF);
        run_cmd("snap_acc", 3'd2, 2'd3, 2'd1, 2'd0, 1'b0, 1, 2'd1, 16'h1234);
        run_cmd("snap_exec", 3'd0, 2'd0, 2'd1, 2'd2, 1'b0, 2, 2'd1, 16'h5A5A);

        // cmd_valid held high: one accept every 3 cycles
        acc = 0; dn = 0; last_acc = -1;
        cmd_valid = 1'b1;
        for (int cyc = 0; cyc < 30 && dn < 4; cyc++) begin
            if (cmd_ready && acc < 4) begin
                cmd_op = b_op[acc]; cmd_rd = b_rd[acc]; cmd_rs1 = b_rs1[acc];
                cmd_rs2 = b_rs2[acc]; cmd_use_c = 1'b1;
                push_cmd(b_op[acc], b_rd[acc], b_rs1[acc], b_rs2[acc], 1'b1);
                if (last_acc >= 0) check("b2b_spacing", cyc - last_acc, 3);
                last_acc = cyc;
                acc++;
                tick();
                if (acc == 4) cmd_valid = 1'b0;
            end else begin
                tick();
            end
            if (done) begin
                dn++;
                check_writeback("b2b_wb");
            end
        end
        cmd_valid = 1'b0;
        check("b2b_accepts", acc, 4);
        check("b2b_dones", dn, 4);
        check("b2b_sb_empty", sb.size(), 0);

        // reset during EXEC aborts the command and overrides a load
        do_ld(2'd0, 16'hFFFF);
        do_ld(2'd1, 16'h0002);
        run_cmd("pre_rst", 3'd0, 2'd2, 2'd0, 2'd1, 1'b0, 0, 2'd0, 16'h0);
        check("pre_rst_carry_set", carry, 1);
        cmd_valid = 1'b1; cmd_op = 3'd0; cmd_rd = 2'd3; cmd_rs1 = 2'd0; cmd_rs2 = 2'd1;
        cmd_use_c = 1'b0;
        tick();
        cmd_valid = 1'b0;
        check("rst_exec_in_exec", cmd_ready, 0);
        rst = 1'b1;
        ld_valid = 1'b1; ld_addr = 2'd1; ld_data = 16'hAAAA;
        tick();
        rst = 1'b0;
        ld_valid = 1'b0;
        m_rf = '{default: '0};
        m_carry = 1'b0;
        check("rst_exec_ready", cmd_ready, 1);
        check("rst_exec_done", done, 0);
        check("rst_exec_carry", carry, 0);
        check("rst_exec_alu", {alu_a, alu_b, alu_cin, alu_ctrl}, 0);
        check_regs("rst_exec_rf");
        tick();
        check("rst_exec_no_done", done, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
